// File: rtl/add_arbiter.sv
// rtl/add_arbiter.sv - round-robin arbiter sharing one Kogge-Stone adder among NUM_REQ slots
// Result register is freed by res_ready in the same cycle a new slot is granted.

module add_arbiter_prefix_adder #(
  parameter int W = 64
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o,
  output logic         ovf_o
);
  localparam int LV = $clog2(W);

  logic [W-1:0] half_sum;
  logic [W-1:0] g, p, g_n, p_n;
  logic [W:0]   carry;

  assign half_sum = a_i ^ b_i;

  // cin is folded into bit 0's generate so the prefix tree yields carry[i+1] = G[i:0]
  always_comb begin
    g    = a_i & b_i;
    p    = a_i ^ b_i;
    g[0] = g[0] | (p[0] & cin_i);
    g_n  = g;
    p_n  = p;
    for (int l = 0; l < LV; l++) begin
      g_n = g;
      p_n = p;
      for (int i = (1 << l); i < W; i++) begin
        g_n[i] = g[i] | (p[i] & g[i - (1 << l)]);
        p_n[i] = p[i] & p[i - (1 << l)];
      end
      g = g_n;
      p = p_n;
    end
  end

  assign carry  = {g, cin_i};
  assign sum_o  = half_sum ^ carry[W-1:0];
  assign cout_o = carry[W];
  assign ovf_o  = carry[W] ^ carry[W-1];
endmodule

module add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_sub,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         res_sum,
  output logic                     res_cout,
  output logic                     res_ovf,
  output logic [2:0]               res_id
);
  logic [2:0]       last_q, last_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [2:0]       id_q, id_d;

  logic [7:0]       valid_ext;
  logic [3:0]       cand;
  logic [2:0]       grant_idx;
  logic             grant_found;
  logic             res_free;
  logic             accept;

  logic [WIDTH-1:0] a_sel, b_sel, b_eff, add_sum;
  logic             sub_sel, add_cout, add_ovf;

  assign valid_ext = 8'(req_valid);

  // Search from the slot after the last accepted grant, wrapping at NUM_REQ
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 3'd0;
    cand        = 4'd0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = {1'b0, last_q} + 4'(off);
      if (cand >= 4'(NUM_REQ)) cand = cand - 4'(NUM_REQ);
      if (!grant_found && valid_ext[cand[2:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[2:0];
      end
    end
  end

  assign res_free  = !valid_q || res_ready;
  assign accept    = rst_n && res_free && grant_found;
  assign req_ready = accept ? (NUM_REQ'(1) << grant_idx) : '0;

  always_comb begin
    a_sel   = '0;
    b_sel   = '0;
    sub_sel = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == 3'(i)) begin
        a_sel   = req_a[i*WIDTH +: WIDTH];
        b_sel   = req_b[i*WIDTH +: WIDTH];
        sub_sel = req_sub[i];
      end
    end
  end

  assign b_eff = sub_sel ? ~b_sel : b_sel;

  add_arbiter_prefix_adder #(.W(WIDTH)) u_adder (
    .a_i    (a_sel),
    .b_i    (b_eff),
    .cin_i  (sub_sel),
    .sum_o  (add_sum),
    .cout_o (add_cout),
    .ovf_o  (add_ovf)
  );

  always_comb begin
    last_d  = last_q;
    valid_d = valid_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    id_d    = id_q;
    if (accept) begin
      last_d  = grant_idx;
      valid_d = 1'b1;
      sum_d   = add_sum;
      cout_d  = add_cout;
      ovf_d   = add_ovf;
      id_d    = grant_idx;
    end else if (res_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q  <= 3'(NUM_REQ - 1);
      valid_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      id_q    <= 3'd0;
    end else begin
      last_q  <= last_d;
      valid_q <= valid_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      id_q    <= id_d;
    end
  end

  assign res_valid = valid_q;
  assign res_sum   = sum_q;
  assign res_cout  = cout_q;
  assign res_ovf   = ovf_q;
  assign res_id    = id_q;
endmodule

// File: tb/tb_add_arbiter.sv
// tb/tb_add_arbiter.sv - directed and random checks of add_arbiter against an arithmetic model

module tb_add_arbiter;
  localparam int N = 4;
  localparam int W = 64;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid, req_ready, req_sub;
  logic [N*W-1:0] req_a, req_b;
  logic           res_valid, res_ready;
  logic [W-1:0]   res_sum;
  logic           res_cout, res_ovf;
  logic [2:0]     res_id;

  add_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_cout(res_cout), .res_ovf(res_ovf), .res_id(res_id)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  logic [W-1:0] op_a [N];
  logic [W-1:0] op_b [N];
  logic         op_s [N];

  int           m_last;
  bit           m_vld;
  logic [W-1:0] m_sum;
  bit           m_cout, m_ovf;
  int           m_id;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_last = N - 1;
    m_vld  = 1'b0;
    m_sum  = '0;
    m_cout = 1'b0;
    m_ovf  = 1'b0;
    m_id   = 0;
  endtask

  // Signed overflow from operand/result signs; carry from a widened add or a compare
  task automatic model_exec(input int g);
    logic [W:0] t;
    if (op_s[g]) begin
      m_sum  = op_a[g] - op_b[g];
      m_cout = (op_a[g] >= op_b[g]);
      m_ovf  = (op_a[g][W-1] != op_b[g][W-1]) && (m_sum[W-1] != op_a[g][W-1]);
    end else begin
      t      = {1'b0, op_a[g]} + {1'b0, op_b[g]};
      m_sum  = t[W-1:0];
      m_cout = t[W];
      m_ovf  = (op_a[g][W-1] == op_b[g][W-1]) && (m_sum[W-1] != op_a[g][W-1]);
    end
    m_id   = g;
    m_last = g;
    m_vld  = 1'b1;
  endtask

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = op_a[i];
      req_b[i*W +: W] = op_b[i];
      req_sub[i]      = op_s[i];
    end
  endtask

  task automatic set_slot(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    op_a[i] = a;
    op_b[i] = b;
    op_s[i] = s;
    pack();
  endtask

  // Check at the falling edge, advance the model at the rising edge, return 1 ns later
  task automatic cycle(input string tag);
    int g;
    logic [N-1:0] er;
    @(negedge clk);
    g  = pick(req_valid, m_last);
    er = '0;
    if (rst_n && (!m_vld || res_ready) && g >= 0) er[g] = 1'b1;
    chk({tag, ".ready"}, 64'(req_ready), 64'(er));
    chk({tag, ".valid"}, 64'(res_valid), 64'(m_vld));
    if (m_vld) begin
      chk({tag, ".sum"},  res_sum,          m_sum);
      chk({tag, ".cout"}, 64'(res_cout),    64'(m_cout));
      chk({tag, ".ovf"},  64'(res_ovf),     64'(m_ovf));
      chk({tag, ".id"},   64'(res_id),      64'(m_id));
    end
    @(posedge clk);
    if (!rst_n)          model_reset();
    else if (er != '0)   model_exec(g);
    else if (res_ready)  m_vld = 1'b0;
    #1;
  endtask

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b0, {(W-1){1'b1}}};
      3:       return {1'b1, {(W-1){1'b0}}};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    model_reset();
    rst_n     = 1'b0;
    res_ready = 1'b0;
    req_valid = '1;
    for (int i = 0; i < N; i++) set_slot(i, W'(i + 1), W'(i + 10), 1'b0);

    // Reset state, with requests already pending
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", 64'(res_valid), 64'd0);
    chk("rst.ready", 64'(req_ready), 64'd0);
    chk("rst.sum",   res_sum,        64'd0);
    chk("rst.cout",  64'(res_cout),  64'd0);
    chk("rst.ovf",   64'(res_ovf),   64'd0);
    chk("rst.id",    64'(res_id),    64'd0);
    cycle("rst_cyc");

    // Single slot 2 request: 5 + 7
    rst_n     = 1'b1;
    res_ready = 1'b1;
    req_valid = 4'b0100;
    set_slot(2, 64'd5, 64'd7, 1'b0);
    #1;
    chk("s2.ready", 64'(req_ready), 64'b0100);
    cycle("s2");
    chk("s2.sum",  res_sum,        64'd12);
    chk("s2.id",   64'(res_id),    64'd2);
    chk("s2.cout", 64'(res_cout),  64'd0);
    chk("s2.ovf",  64'(res_ovf),   64'd0);
    req_valid = '0;
    cycle("s2_drain");

    // Round robin with every slot valid: after a reset the order is 0,1,2,3,0
    rst_n = 1'b0;
    #1;
    model_reset();
    cycle("rr_rst");
    rst_n     = 1'b1;
    req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr.seq", 64'(req_ready), 64'(4'b0001 << (k % 4)));
      cycle("rr");
    end
    req_valid = '0;
    cycle("rr_drain");

    // Borrow and signed overflow corners
    set_slot(0, 64'd0, 64'd1, 1'b1);
    set_slot(1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    req_valid = 4'b0001;
    cycle("c0");
    chk("c0.sum",  res_sum,       64'hFFFF_FFFF_FFFF_FFFF);
    chk("c0.cout", 64'(res_cout), 64'd0);
    chk("c0.ovf",  64'(res_ovf),  64'd0);
    req_valid = 4'b0010;
    cycle("c1");
    chk("c1.sum", res_sum,      64'h8000_0000_0000_0000);
    chk("c1.ovf", 64'(res_ovf), 64'd1);
    req_valid = '0;
    cycle("c_drain");

    // Backpressure: hold res_ready low with everything pending
    for (int i = 0; i < N; i++) set_slot(i, rand_op(), rand_op(), 1'($urandom));
    req_valid = 4'b0100;
    cycle("bp_fill");
    req_valid = '1;
    res_ready = 1'b0;
    repeat (3) cycle("bp_stall");
    res_ready = 1'b1;
    #1;
    chk("bp.resume", 64'(req_ready), 64'b1000);
    cycle("bp_resume");
    cycle("bp_next");

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      req_valid = N'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) set_slot(i, rand_op(), rand_op(), 1'($urandom));
      cycle("rnd");
    end

    // Asynchronous reset while a result is held
    res_ready = 1'b1;
    req_valid = 4'b0010;
    cycle("ar_fill");
    req_valid = '1;
    res_ready = 1'b0;
    #1;
    chk("ar.held", 64'(res_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("ar.valid", 64'(res_valid), 64'd0);
    chk("ar.ready", 64'(req_ready), 64'd0);
    chk("ar.sum",   res_sum,        64'd0);
    model_reset();
    cycle("ar_low");
    rst_n     = 1'b1;
    res_ready = 1'b1;
    #1;
    chk("ar.first", 64'(req_ready), 64'b0001);
    cycle("ar_rel");
    cycle("ar_next");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesting issue slots (2..8).
REQ-002 Parameter WIDTH, default 64, operand/result width; only 64 is supported by the shared prefix adder.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 req_valid  in  NUM_REQ  per-slot request valid.
REQ-007 req_ready  out  NUM_REQ  per-slot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-008 req_a  in  NUM_REQ*WIDTH  packed operand A per slot (slot i at [i*WIDTH +: WIDTH]).
REQ-009 req_b  in  NUM_REQ*WIDTH  packed operand B per slot.
REQ-010 req_sub  in  NUM_REQ  per-slot op select: 0 = A+B, 1 = A-B.
REQ-011 res_valid  out  1  result register holds an unconsumed result.
REQ-012 res_ready  in  1  consumer accepts result.
REQ-013 res_sum  out  WIDTH  registered sum/difference.
REQ-014 res_cout  out  1  registered carry out of the MSB.
REQ-015 res_ovf  out  1  registered signed overflow.
REQ-016 res_id  out  3  index of the slot that issued the result.

Function
REQ-017 Block SHALL instantiate exactly one 64-bit parallel-prefix adder and share it among all slots.
REQ-018 Block SHALL grant at most one slot per cycle; req_ready SHALL be one-hot or zero.
REQ-019 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod NUM_REQ; the first slot with req_valid high is granted.
REQ-020 last_grant SHALL update only on an accepted transfer.
REQ-021 req_ready SHALL be asserted only when the result register is free this cycle: res_valid low, or res_valid and res_ready both high.
REQ-022 When res_valid is high and res_ready is low, all req_ready SHALL be low, and result outputs SHALL hold stable.
REQ-023 Adder inputs SHALL be A, B and cin=0 for add; A, ~B and cin=1 for sub.
REQ-024 On an accepted transfer in cycle N, res_sum/res_cout/res_ovf/res_id SHALL be loaded and res_valid SHALL be high in cycle N+1 (latency 1).
REQ-025 Throughput SHALL be one operation per cycle when res_ready is held high.
REQ-026 res_ovf SHALL equal the XOR of the carry into and the carry out of bit WIDTH-1.
REQ-027 res_cout for sub SHALL be the raw adder carry (1 = no borrow).
REQ-028 res_valid SHALL clear on res_ready when no new transfer occurs in the same cycle.
REQ-029 Simultaneous consume and accept SHALL keep res_valid high and load the new result.
REQ-030 The pointer SHALL wrap from NUM_REQ-1 to 0.
REQ-031 Arbitration SHALL be combinational from req_valid and the pointer; no request SHALL be stored before grant.
REQ-032 A slot that withdraws req_valid before grant SHALL lose nothing, and no result SHALL be generated for it.

Reset
REQ-033 While rst_n is low: res_valid=0, res_sum=0, res_cout=0, res_ovf=0, res_id=0, req_ready=0, and last_grant=NUM_REQ-1, so slot 0 has first priority.
REQ-034 Reset asserted mid-operation SHALL discard any held result, with no partial output after release.
REQ-035 The first grant SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-036 Only slot 2 valid with A=5, B=7, add, and res_ready=1: req_ready=0100, and the next cycle gives res_sum=12, res_id=2, cout=0, ovf=0.
REQ-037 All 4 slots valid continuously with res_ready=1: grants run 0,1,2,3,0 on consecutive cycles, with res_valid high every cycle after the first.
REQ-038 Slot 0 sub with A=0, B=1: res_sum=all ones, cout=0, ovf=0. Slot 1 add with A=0x7FFF_FFFF_FFFF_FFFF, B=1: res_sum=0x8000_0000_0000_0000, ovf=1.
REQ-039 res_ready held 0 for 3 cycles with slots pending: req_ready=0 and res_* stable; on res_ready=1, the next slot in round-robin order is granted the same cycle.
REQ-040 rst_n pulsed low while res_valid=1: res_valid=0 immediately (asynchronous), and after release slot 0 wins if all slots are valid.
